// File: rtl/apb_req_bridge.sv
// APB requester: command/response handshake front end driving
// the APB SETUP/ACCESS sequence to one of NUM_SLAVES completers.
module apb_req_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int REGION_BITS    = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  output logic [2:0]                       pprot,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int SB   = DATA_WIDTH / 8;
  localparam int CLOG = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
  localparam int SW   = (CLOG > 0) ? CLOG : 1;
  localparam int AL   = $clog2(SB);
  localparam int TW   = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'((64'd1 << AL) - 64'd1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic            init_q;
  logic [SW-1:0]   sidx_q;
  logic [TW-1:0]   wait_q;
  logic [SW-1:0]   sidx;
  logic [ADDR_WIDTH-1:0] upper;
  logic            dec_err;
  logic            align_err;
  logic            bad;
  logic            accept;
  logic            sel_ready;
  logic            sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic            timeout_hit;

  assign sidx      = (CLOG > 0) ? SW'(cmd_addr >> REGION_BITS) : '0;
  assign upper     = cmd_addr >> (REGION_BITS + CLOG);
  assign dec_err   = (upper != '0) || (32'(sidx) >= NUM_SLAVES);
  assign align_err = (cmd_addr & AMASK) != '0;
  assign bad       = dec_err || align_err;

  assign cmd_ready = (state_q == IDLE) && init_q;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == RESP);
  assign penable   = (state_q == ACCESS);

  assign sel_ready = pready[sidx_q];
  assign sel_err   = pslverr[sidx_q];
  assign sel_rdata = prdata[int'(sidx_q)*DATA_WIDTH +: DATA_WIDTH];

  // Wait counter holds the number of low pready samples already seen,
  // so the limit is reached on the TIMEOUT_CYCLES-th low sample.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !sel_ready &&
                       (wait_q == TLAST);

  // One-hot select is live only during SETUP and ACCESS
  always_comb begin
    psel = '0;
    if (state_q == SETUP || state_q == ACCESS)
      psel[sidx_q] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = bad ? RESP : SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: if (sel_ready || timeout_hit) state_d = RESP;
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; init_q holds off cmd_ready until the first edge
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Latch the command into the APB bus registers and build the response
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sidx_q      <= '0;
      wait_q      <= '0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_rdata   <= '0;
            rsp_err     <= bad;
            rsp_timeout <= 1'b0;
            if (!bad) begin
              sidx_q <= sidx;
              pwrite <= cmd_write;
              paddr  <= cmd_addr;
              pwdata <= cmd_wdata;
              pstrb  <= cmd_write ? cmd_strb : '0;
              pprot  <= cmd_prot;
            end
          end
        end
        SETUP: wait_q <= '0;
        ACCESS: begin
          if (sel_ready) begin
            rsp_err   <= sel_err;
            rsp_rdata <= (!pwrite && !sel_err) ? sel_rdata : '0;
          end else if (timeout_hit) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge with immediate-assertion checks
// and hand-computed expected values.
module tb_apb_req_bridge;

  logic         pclk;
  logic         presetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic [3:0]   cmd_strb;
  logic [2:0]   cmd_prot;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         rsp_timeout;
  logic [3:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [127:0] prdata;
  logic [3:0]   pready;
  logic [3:0]   pslverr;

  int checks = 0;
  int errors = 0;

  apb_req_bridge dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = '0;
    pslverr   = '0;

    // reset state
    #2;
    chk("rst_psel", psel, 4'h0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    #20 presetn = 1'b1;
    tick();
    chk("init_cmd_ready", cmd_ready, 1'b1);

    // zero-wait read from completer 2
    pready = 4'b0100;
    prdata[2*32 +: 32] = 32'hDEAD_BEEF;
    send(1'b0, 32'h0000_2004, 32'h0, 4'hF, 3'b000);
    chk("rd_setup_psel", psel, 4'b0100);
    chk("rd_setup_pen", penable, 1'b0);
    chk("rd_setup_paddr", paddr, 32'h2004);
    chk("rd_setup_pstrb", pstrb, 4'b0000);
    chk("rd_busy_ready", cmd_ready, 1'b0);
    tick();
    chk("rd_acc_pen", penable, 1'b1);
    chk("rd_acc_psel", psel, 4'b0100);
    chk("rd_acc_rv", rsp_valid, 1'b0);
    tick();
    chk("rd_rv", rsp_valid, 1'b1);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", rsp_err, 1'b0);
    chk("rd_psel_drop", psel, 4'b0000);
    chk("rd_pen_drop", penable, 1'b0);
    handshake();
    chk("rd_hs_rv", rsp_valid, 1'b0);
    chk("rd_hs_ready", cmd_ready, 1'b1);

    // write with three wait states to completer 1
    pready = 4'b0000;
    send(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 3'b000);
    chk("wr_setup_psel", psel, 4'b0010);
    chk("wr_setup_pwrite", pwrite, 1'b1);
    chk("wr_setup_pstrb", pstrb, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_acc_pen", penable, 1'b1);
      chk("wr_acc_pwdata", pwdata, 32'h1234_5678);
      chk("wr_acc_pstrb", pstrb, 4'b0011);
      chk("wr_acc_paddr", paddr, 32'h1000);
      chk("wr_acc_rv", rsp_valid, 1'b0);
    end
    pready = 4'b0010;
    tick();
    chk("wr_rv", rsp_valid, 1'b1);
    chk("wr_err", rsp_err, 1'b0);
    chk("wr_rdata", rsp_rdata, 32'h0);
    handshake();

    // decode error: completer index 4
    send(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000);
    chk("dec_rv", rsp_valid, 1'b1);
    chk("dec_err", rsp_err, 1'b1);
    chk("dec_to", rsp_timeout, 1'b0);
    chk("dec_psel", psel, 4'b0000);
    handshake();

    // decode error: bit above the select field
    send(1'b0, 32'h0001_0000, 32'h0, 4'h0, 3'b000);
    chk("dec_hi_rv", rsp_valid, 1'b1);
    chk("dec_hi_err", rsp_err, 1'b1);
    chk("dec_hi_psel", psel, 4'b0000);
    handshake();

    // alignment error
    send(1'b0, 32'h0000_0003, 32'h0, 4'h0, 3'b000);
    chk("aln_rv", rsp_valid, 1'b1);
    chk("aln_err", rsp_err, 1'b1);
    chk("aln_psel", psel, 4'b0000);
    handshake();

    // completer error response on completer 3
    pready  = 4'b1000;
    pslverr = 4'b1000;
    send(1'b1, 32'h0000_3000, 32'hCAFE_0000, 4'hF, 3'b000);
    tick();
    tick();
    chk("slv_rv", rsp_valid, 1'b1);
    chk("slv_err", rsp_err, 1'b1);
    chk("slv_to", rsp_timeout, 1'b0);
    handshake();

    // timeout: completer 3 never ready, other completers ready
    pready  = 4'b0111;
    pslverr = 4'b0111;
    prdata[3*32 +: 32] = 32'h5555_AAAA;
    send(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000);
    tick();
    for (int i = 2; i <= 16; i++) tick();
    chk("to_e16_psel", psel, 4'b1000);
    chk("to_e16_rv", rsp_valid, 1'b0);
    tick();
    chk("to_psel", psel, 4'b0000);
    chk("to_pen", penable, 1'b0);
    chk("to_rv", rsp_valid, 1'b1);
    chk("to_err", rsp_err, 1'b1);
    chk("to_flag", rsp_timeout, 1'b1);
    chk("to_rdata", rsp_rdata, 32'h0);
    handshake();

    // pready rising on the timeout edge completes normally
    pready  = 4'b0000;
    pslverr = 4'b0000;
    send(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000);
    tick();
    for (int i = 2; i <= 16; i++) tick();
    pready = 4'b1000;
    tick();
    chk("late_rv", rsp_valid, 1'b1);
    chk("late_err", rsp_err, 1'b0);
    chk("late_to", rsp_timeout, 1'b0);
    chk("late_rdata", rsp_rdata, 32'h5555_AAAA);
    handshake();

    // backpressure and pprot
    pready = 4'b0010;
    prdata[1*32 +: 32] = 32'hA5A5_0001;
    send(1'b0, 32'h0000_1008, 32'h0, 4'h0, 3'b101);
    chk("bp_prot_setup", pprot, 3'b101);
    tick();
    chk("bp_prot_acc", pprot, 3'b101);
    tick();
    chk("bp_rv", rsp_valid, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_1000;
    cmd_prot  = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_rv", rsp_valid, 1'b1);
      chk("bp_hold_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("bp_hold_ready", cmd_ready, 1'b0);
      chk("bp_hold_psel", psel, 4'b0000);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", cmd_ready, 1'b1);
    chk("bp_idle_psel", psel, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_psel", psel, 4'b0010);
    chk("bp_next_prot", pprot, 3'b000);
    tick();
    tick();
    chk("bp_next_rv", rsp_valid, 1'b1);
    handshake();

    // reset during a wait-state read
    pready = 4'b0000;
    send(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    chk("rm_pre_pen", penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    chk("rm_psel", psel, 4'b0000);
    chk("rm_pen", penable, 1'b0);
    chk("rm_rv", rsp_valid, 1'b0);
    chk("rm_paddr", paddr, 32'h0);
    #10 presetn = 1'b1;
    tick();
    chk("rm_ready", cmd_ready, 1'b1);
    pready = 4'b0100;
    prdata[2*32 +: 32] = 32'h0BAD_F00D;
    send(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    chk("rm_rd_rv", rsp_valid, 1'b1);
    chk("rm_rd_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("rm_rd_err", rsp_err, 1'b0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
# apb_req_bridge

Synthesizable, parametrised APB requester. Accepts read/write commands on a valid/ready command port, decodes the target completer from the address, and runs the APB SETUP/ACCESS sequence to one of NUM_SLAVES completers. It returns read data, error and timeout status on a valid/ready response port. It sits between a system-side command source and the APB completers (register blocks, protection unit), replacing behavioural requester tasks in benches and in the SoC fabric.

## Interface
- ADDR_WIDTH, 32, paddr/cmd_addr width
- DATA_WIDTH, 32, data width; legal values 8, 16, 32
- NUM_SLAVES, 4, number of completers (≥1); one psel bit each
- REGION_BITS, 12, log2 of each completer's address window
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready; 0 disables timeout
- pclk  in  1  clock
- presetn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  pprot value for the transfer
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  pslverr, decode error, alignment error or timeout
- rsp_timeout  out  1  error caused by timeout
- psel  out  NUM_SLAVES  one-hot completer select
- penable, pwrite  out  1  APB controls
- paddr  out  ADDR_WIDTH;  pwdata  out  DATA_WIDTH;  pstrb  out  DATA_WIDTH/8;  pprot  out  3
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-completer read data, completer i at [i*DATA_WIDTH +: DATA_WIDTH]
- pready, pslverr  in  NUM_SLAVES  per-completer ready and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. cmd_ready = (state == IDLE).
- In IDLE, cmd_valid & cmd_ready latches all cmd fields.
- Decode: SIDX = cmd_addr[REGION_BITS +: clog2(NUM_SLAVES)]. A decode error occurs when SIDX ≥ NUM_SLAVES or any address bit above that field is 1.
- Alignment: cmd_addr[clog2(DATA_WIDTH/8)-1:0] must be 0.
- On a decode or alignment error, the FSM goes IDLE→RESP with rsp_err=1. No psel is driven.
- Otherwise the FSM goes IDLE→SETUP:
  - psel[SIDX]=1, penable=0.
  - paddr, pwrite, pprot and pwdata come from the latched command.
  - pstrb = cmd_strb for writes and 0 for reads.
- SETUP→ACCESS unconditionally; penable=1.
- ACCESS with pready[SIDX]=1 → RESP:
  - Capture prdata[SIDX] (reads only) and pslverr[SIDX] into rsp_rdata/rsp_err.
  - psel and penable drop to 0.
- ACCESS with pready low: a wait counter increments. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES → RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0. psel and penable drop.
- RESP: rsp_valid=1. Response fields are held stable until rsp_ready. The handshake → IDLE.
- The address, control and data outputs stay stable from SETUP through the end of ACCESS.
- pready and pslverr from unselected completers are ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, and every one of these outputs is 0: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
- cmd_ready is 1 from the first pclk edge after presetn deasserts.
- Command accepted at edge E0 (valid transfer):
  - SETUP during E0–E1.
  - ACCESS from E1.
  - With zero wait states, pready is sampled at E2 and rsp_valid is high after E2.
  - cmd_ready returns after the rsp handshake edge.
- With N wait states, rsp_valid rises after edge E2+N.
- Decode/alignment error: rsp_valid high after E0, with no APB activity.
- Timeout fires at edge E1+TIMEOUT_CYCLES if pready never rises. pready arriving on that same edge wins: a normal completion, not a timeout.
- Back-to-back transfers: psel is low for at least one cycle between transfers, i.e. at least one RESP cycle plus one IDLE cycle.
- presetn asserted mid-transfer aborts immediately. psel and penable go low asynchronously, and no response is produced.

## Test plan
- Zero-wait read, NUM_SLAVES=4, REGION_BITS=12:
  - Stimulus: cmd_addr=0x0000_2004, completer 2 returns prdata=0xDEAD_BEEF.
  - Required: psel=4'b0100, paddr=0x2004, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 edges after accept.
- Write with 3 wait states:
  - Stimulus: cmd_addr=0x1000, cmd_wdata=0x1234_5678, cmd_strb=4'b0011, pready low 3 cycles.
  - Required: pstrb=4'b0011 and pwdata stable throughout ACCESS; rsp_err=0; rsp_valid after E5.
- Error paths:
  - cmd_addr=0x0000_4000 (SIDX=4) → no psel, rsp_err=1 after 1 edge.
  - cmd_addr=0x3 → same.
  - pslverr=1 with pready → rsp_err=1, rsp_timeout=0.
- Timeout, TIMEOUT_CYCLES=16, pready held low:
  - Required: psel drops at E17; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with pready rising exactly at E17 → normal completion.
- Backpressure and pprot:
  - Stimulus: rsp_ready held low 5 cycles; cmd_prot=3'b101.
  - Required: response stable, cmd_ready=0, pprot=3'b101 during transfer, next command accepted only after the handshake.
- Reset mid-ACCESS:
  - Stimulus: presetn=0 during a wait-state read.
  - Required: psel=0, penable=0, rsp_valid=0 immediately; a subsequent read after release completes normally.
